// File: rtl/rv32i_hazard_ctrl_if.sv
// rtl/rv32i_hazard_ctrl_if.sv - ID decode, EX/MEM status and pipeline control bundle for the hazard controller
interface rv32i_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [6:0]       id_opcode;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ack;

   logic             stall_pc;
   logic             stall_id;
   logic             flush_id;
   logic             bubble_ex;
   logic             freeze;
   logic [1:0]       state;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] freeze_cnt;

   modport master (
      output id_valid, id_opcode, id_rs1, id_rs2, id_rd,
      output ex_branch_taken, mem_req, mem_ack,
      input  stall_pc, stall_id, flush_id, bubble_ex, freeze,
      input  state, mem_timeout, stall_cnt, flush_cnt, freeze_cnt
   );

   modport slave (
      input  id_valid, id_opcode, id_rs1, id_rs2, id_rd,
      input  ex_branch_taken, mem_req, mem_ack,
      output stall_pc, stall_id, flush_id, bubble_ex, freeze,
      output state, mem_timeout, stall_cnt, flush_cnt, freeze_cnt
   );
endinterface

// File: rtl/rv32i_hazard_ctrl.sv
// rtl/rv32i_hazard_ctrl.sv - load-use stall, branch flush and data-memory freeze control for the 5-stage RV32I pipe
module rv32i_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   rv32i_hazard_ctrl_if.slave   bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [4:0]         r_ex_rd;
   logic               r_ex_load;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic               r_mem_timeout;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;
   logic [CNT_W-1:0]   r_freeze_cnt;

   logic               w_uses_rs1;
   logic               w_uses_rs2;
   logic               w_load_use;
   logic               w_mem_stall;
   logic               w_freeze_cond;
   logic               w_stall_pc;
   logic               w_stall_id;
   logic               w_flush_id;
   logic               w_bubble_ex;
   logic               w_freeze;
   logic               w_id_is_load;

   always_comb begin
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      case (bus.id_opcode)
         7'h03, 7'h13, 7'h67: w_uses_rs1 = 1'b1;
         7'h23, 7'h33, 7'h63: begin
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_id_is_load = bus.id_valid && (bus.id_opcode == 7'h03);

   assign w_load_use = bus.id_valid && r_ex_load && (r_ex_rd != 5'd0) &&
                       ((w_uses_rs1 && (bus.id_rs1 == r_ex_rd)) ||
                        (w_uses_rs2 && (bus.id_rs2 == r_ex_rd)));

   assign w_mem_stall   = bus.mem_req && !bus.mem_ack;
   assign w_freeze_cond = w_mem_stall || ((r_state == ST_MEM_WAIT) && !bus.mem_ack);

   // Freeze dominates: EX holds during a freeze and re-presents any taken branch afterwards.
   always_comb begin
      w_stall_pc  = 1'b0;
      w_stall_id  = 1'b0;
      w_flush_id  = 1'b0;
      w_bubble_ex = 1'b0;
      w_freeze    = 1'b0;
      if (!rst) begin
         if (w_freeze_cond) begin
            w_freeze = 1'b1;
         end else if (bus.ex_branch_taken) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
         end else if (w_load_use) begin
            w_stall_pc  = 1'b1;
            w_stall_id  = 1'b1;
            w_bubble_ex = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:      if (w_mem_stall) w_state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (bus.mem_ack) w_state_nxt = ST_RUN;
         default:     w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_rd   <= 5'd0;
         r_ex_load <= 1'b0;
      end else if (!w_freeze) begin
         r_ex_load <= w_id_is_load && !w_bubble_ex;
         r_ex_rd   <= (w_id_is_load && !w_bubble_ex) ? bus.id_rd : 5'd0;
      end
   end

   // wait_cnt parks at MEM_TIMEOUT-1 so it never wraps during a hung access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         if ((r_state == ST_RUN) && (w_state_nxt == ST_MEM_WAIT)) begin
            r_wait_cnt <= '0;
         end else if ((r_state == ST_MEM_WAIT) &&
                      (r_wait_cnt != WAIT_W'(MEM_TIMEOUT - 1))) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if ((r_state == ST_MEM_WAIT) && !bus.mem_ack &&
             (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
            r_mem_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_freeze_cnt <= '0;
      end else begin
         if (w_stall_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush_id && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
         if (w_freeze && (r_freeze_cnt != {CNT_W{1'b1}})) begin
            r_freeze_cnt <= r_freeze_cnt + 1'b1;
         end
      end
   end

   assign bus.stall_pc    = w_stall_pc;
   assign bus.stall_id    = w_stall_id;
   assign bus.flush_id    = w_flush_id;
   assign bus.bubble_ex   = w_bubble_ex;
   assign bus.freeze      = w_freeze;
   assign bus.state       = r_state;
   assign bus.mem_timeout = r_mem_timeout;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;
   assign bus.freeze_cnt  = r_freeze_cnt;
endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb/tb_rv32i_hazard_ctrl.sv - directed self-checking bench for rv32i_hazard_ctrl
module tb_rv32i_hazard_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   rv32i_hazard_ctrl_if #(.CNT_W(32)) hz_if ();

   rv32i_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hz_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
      hz_if.id_valid  = v;
      hz_if.id_opcode = op;
      hz_if.id_rs1    = rs1;
      hz_if.id_rs2    = rs2;
      hz_if.id_rd     = rd;
   endtask

   task automatic set_mem(input logic req, input logic ack, input logic br);
      hz_if.mem_req         = req;
      hz_if.mem_ack         = ack;
      hz_if.ex_branch_taken = br;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check_ctl(input string tag, input logic spc, input logic sid,
                            input logic fid, input logic bex, input logic frz);
      check({tag, ".stall_pc"},  {31'd0, hz_if.stall_pc},  {31'd0, spc});
      check({tag, ".stall_id"},  {31'd0, hz_if.stall_id},  {31'd0, sid});
      check({tag, ".flush_id"},  {31'd0, hz_if.flush_id},  {31'd0, fid});
      check({tag, ".bubble_ex"}, {31'd0, hz_if.bubble_ex}, {31'd0, bex});
      check({tag, ".freeze"},    {31'd0, hz_if.freeze},    {31'd0, frz});
   endtask

   task automatic check_cnt(input string tag, input int sc, input int fc, input int zc);
      check({tag, ".stall_cnt"},  hz_if.stall_cnt,  sc);
      check({tag, ".flush_cnt"},  hz_if.flush_cnt,  fc);
      check({tag, ".freeze_cnt"}, hz_if.freeze_cnt, zc);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      set_id(1'b1, 7'h33, 5'd5, 5'd5, 5'd6);
      set_mem(1'b1, 1'b0, 1'b1);
      #1;
      settle();
      check_ctl("rst_force", 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check("reset.state", {30'd0, hz_if.state}, 0);
      check("reset.timeout", {31'd0, hz_if.mem_timeout}, 0);
      check_cnt("reset", 0, 0, 0);
      check_ctl("reset", 0, 0, 0, 0, 0);

      // LW x5 then ADD x6,x5,x1: one stall cycle
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd5);
      settle();
      check_ctl("lw_issue", 0, 0, 0, 0, 0);
      tick();
      set_id(1'b1, 7'h33, 5'd5, 5'd1, 5'd6);
      settle();
      check_ctl("lu_stall", 1, 1, 0, 1, 0);
      tick();
      settle();
      check_ctl("lu_release", 0, 0, 0, 0, 0);
      check_cnt("lu", 1, 0, 0);

      // LW x5 then LUI x5: no stall
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd5);
      tick();
      set_id(1'b1, 7'h37, 5'd5, 5'd5, 5'd5);
      settle();
      check_ctl("lui", 0, 0, 0, 0, 0);
      // LW x5 then JAL: no stall
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd5);
      tick();
      set_id(1'b1, 7'h6F, 5'd5, 5'd5, 5'd1);
      settle();
      check_ctl("jal", 0, 0, 0, 0, 0);
      // LW x0 then ADD rs1=x0: no stall
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd0);
      tick();
      set_id(1'b1, 7'h33, 5'd0, 5'd0, 5'd6);
      settle();
      check_ctl("x0", 0, 0, 0, 0, 0);
      // LW x7 then SW with rs2=x7: stall via rs2
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd7);
      tick();
      set_id(1'b1, 7'h23, 5'd2, 5'd7, 5'd0);
      settle();
      check_ctl("sw_rs2", 1, 1, 0, 1, 0);
      tick();
      set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
      settle();
      check_cnt("after_sw", 2, 0, 0);

      // branch wins over load-use
      tick();
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd5);
      tick();
      set_id(1'b1, 7'h33, 5'd5, 5'd1, 5'd6);
      set_mem(1'b0, 1'b0, 1'b1);
      settle();
      check_ctl("br_lu", 0, 0, 1, 1, 0);
      tick();
      set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check_cnt("br_lu", 2, 1, 0);

      // 3-cycle memory wait
      set_mem(1'b1, 1'b0, 1'b0);
      settle();
      check_ctl("mw0", 0, 0, 0, 0, 1);
      check("mw0.state", {30'd0, hz_if.state}, 0);
      tick();
      settle();
      check_ctl("mw1", 0, 0, 0, 0, 1);
      check("mw1.state", {30'd0, hz_if.state}, 1);
      tick();
      settle();
      check_ctl("mw2", 0, 0, 0, 0, 1);
      tick();
      set_mem(1'b1, 1'b1, 1'b0);
      settle();
      check_ctl("mw_ack", 0, 0, 0, 0, 0);
      check("mw_ack.state", {30'd0, hz_if.state}, 1);
      tick();
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check("mw_done.state", {30'd0, hz_if.state}, 0);
      check_cnt("mw", 2, 1, 3);

      // single-cycle access
      set_mem(1'b1, 1'b1, 1'b0);
      settle();
      check_ctl("single", 0, 0, 0, 0, 0);
      tick();
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check("single.state", {30'd0, hz_if.state}, 0);

      // freeze defers branch
      set_mem(1'b1, 1'b0, 1'b1);
      settle();
      check_ctl("frz_br0", 0, 0, 0, 0, 1);
      tick();
      set_mem(1'b1, 1'b1, 1'b1);
      settle();
      check_ctl("frz_br1", 0, 0, 1, 1, 0);
      tick();
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check_cnt("frz_br", 2, 2, 4);

      // freeze defers load-use; tracking registers hold across the freeze
      set_id(1'b1, 7'h03, 5'd1, 5'd0, 5'd5);
      tick();
      set_id(1'b1, 7'h33, 5'd5, 5'd1, 5'd6);
      set_mem(1'b1, 1'b0, 1'b0);
      settle();
      check_ctl("frz_lu0", 0, 0, 0, 0, 1);
      tick();
      set_mem(1'b1, 1'b1, 1'b0);
      settle();
      check_ctl("frz_lu1", 1, 1, 0, 1, 0);
      tick();
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check_ctl("frz_lu2", 0, 0, 0, 0, 0);
      set_id(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
      check_cnt("frz_lu", 3, 2, 5);
      check("pre_to.timeout", {31'd0, hz_if.mem_timeout}, 0);

      // timeout with MEM_TIMEOUT=4: six unacked cycles, sets entering the sixth
      for (int i = 0; i < 6; i++) begin
         set_mem(1'b1, 1'b0, 1'b0);
         settle();
         check($sformatf("to%0d.timeout", i), {31'd0, hz_if.mem_timeout}, (i >= 5) ? 32'd1 : 32'd0);
         check($sformatf("to%0d.freeze", i), {31'd0, hz_if.freeze}, 1);
         tick();
      end
      set_mem(1'b1, 1'b1, 1'b0);
      settle();
      check("to_ack.freeze", {31'd0, hz_if.freeze}, 0);
      tick();
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check("to_done.state", {30'd0, hz_if.state}, 0);
      check("to_done.timeout", {31'd0, hz_if.mem_timeout}, 1);
      check_cnt("to_done", 3, 2, 11);

      // reset in the middle of MEM_WAIT
      set_mem(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      settle();
      check("rmw.state", {30'd0, hz_if.state}, 1);
      rst = 1'b1;
      settle();
      check("rmw_rst.freeze", {31'd0, hz_if.freeze}, 0);
      tick();
      rst = 1'b0;
      set_mem(1'b0, 1'b0, 1'b0);
      settle();
      check("rmw_after.state", {30'd0, hz_if.state}, 0);
      check("rmw_after.timeout", {31'd0, hz_if.mem_timeout}, 0);
      check_cnt("rmw_after", 0, 0, 0);
      check_ctl("rmw_after", 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/rv32i_hazard_ctrl.md
# rv32i_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32I core. It observes the decoded fields in ID (the same opcode/rs1/rs2/rd fields the immediate generator consumes) and tracks the instruction entering EX in its own registers. From these it drives the load-use stall, branch/jump flush and data-memory freeze controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: cycles spent in MEM_WAIT before mem_timeout sets.
- CNT_W, 32: width of each performance counter.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rs1  in  5  rs1 field of the ID instruction.
- id_rs2  in  5  rs2 field of the ID instruction.
- id_rd  in  5  rd field of the ID instruction.
- ex_branch_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_req  in  1  MEM stage performs a data-memory access this cycle.
- mem_ack  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold the PC.
- stall_id  out  1  hold IF/ID.
- flush_id  out  1  load NOP into IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- freeze  out  1  hold every pipeline register and the PC.
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT.
- mem_timeout  out  1  sticky; set when a wait reaches MEM_TIMEOUT cycles.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of flush cycles.
- freeze_cnt  out  CNT_W  count of freeze cycles.

## Operation
**Tracking registers**
- ex_rd (5 bits) and ex_load (1 bit) describe the instruction entering EX.
- On each non-freeze edge:
  - ex_load <= id_valid & (id_opcode == 7'h03) & !bubble_ex.
  - ex_rd <= id_rd under the same condition, else 0.
- During freeze both registers hold their value.

**Source usage**
- uses_rs1: opcode is one of 03, 13, 23, 33, 63, 67 (hex).
- uses_rs2: opcode is one of 23, 33, 63 (hex).
- LUI (37), AUIPC (17) and JAL (6F) use no source register.
- Any other opcode uses no source register.

**Hazard conditions**
- load_use = id_valid & ex_load & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- mem_stall = mem_req & !mem_ack.

**Output priority, highest first (combinational from current state and inputs)**
1. freeze = mem_stall | (state == MEM_WAIT & !mem_ack). When freeze is 1, every other control output is 0 and ex_branch_taken is ignored, because EX holds and re-presents it.
2. ex_branch_taken: flush_id = 1, bubble_ex = 1, no stall.
3. load_use: stall_pc = 1, stall_id = 1, bubble_ex = 1.
4. Otherwise all controls are 0.

**FSM**
- RUN -> MEM_WAIT when mem_req & !mem_ack.
- MEM_WAIT -> RUN when mem_ack.
- mem_req dropping while in MEM_WAIT is illegal. The FSM still waits for mem_ack.

**Timeout**
- wait_cnt clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT.
- When wait_cnt == MEM_TIMEOUT-1 and mem_ack is 0, mem_timeout sets.
- mem_timeout stays set until rst. The FSM keeps waiting.

**Performance counters**
- stall_cnt increments on cycles where stall_id is 1.
- flush_cnt increments on cycles where flush_id is 1.
- freeze_cnt increments on cycles where freeze is 1.
- Each counter saturates at 2^CNT_W - 1.

**Reset values**
- While rst is high, all control outputs are forced to 0.
- On the reset edge: state = RUN, ex_rd = 0, ex_load = 0, wait_cnt = 0, mem_timeout = 0, and all counters = 0.
- Reset during MEM_WAIT aborts the wait: state returns to RUN the next cycle.

## Timing
- All controls are valid in the same cycle as the triggering inputs. There is no added latency.
- **Load-use:**
  - Cycle N: load in EX, consumer in ID; stall asserted for exactly 1 cycle.
  - Edge N: bubble enters EX, so ex_load = 0.
  - Cycle N+1: consumer proceeds with no further stall.
- **Branch:** flush_id and bubble_ex are high for exactly the cycles where ex_branch_taken is high and freeze is 0.
- **Memory wait:**
  - A single-cycle access (mem_req & mem_ack together) produces no freeze.
  - A wait of k cycles gives freeze = 1 for k cycles and returns to RUN on the ack edge.
- **Simultaneous events:**
  - Branch plus load-use: branch wins; the consumer is flushed anyway.
  - Freeze plus branch: freeze wins; the flush occurs on the first unfrozen cycle.
  - Load-use plus freeze: the stall is deferred because the tracking registers hold, so load_use re-evaluates after the freeze.
- A load whose rd is x0 never stalls.

## Test plan
- Load x5, then ADD x6,x5,x1 in ID -> stall_pc=stall_id=bubble_ex=1 for exactly 1 cycle; stall_cnt=1; next cycle all 0.
- Load x5 followed by LUI x5 or JAL in ID -> no stall. Load x0 followed by ADD rs1=x0 -> no stall.
- ex_branch_taken pulsed 1 cycle while ID holds a load-use consumer -> flush_id=bubble_ex=1, stall_id=0; flush_cnt=1, stall_cnt=0.
- mem_req high with mem_ack low for 3 cycles, then acked -> freeze=1 for 3 cycles; state=1 during the wait; freeze_cnt=3; mem_ack=1 together with mem_req gives no freeze.
- MEM_TIMEOUT=4 with no ack for 6 cycles -> mem_timeout rises after cycle 4 and stays high after the ack; rst clears it.
- rst asserted mid-MEM_WAIT with the counters nonzero -> next cycle state=0, all counters 0, freeze=0.
